// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (imem) and data (dmem) requesters, one request in flight.
// Optional ARB_ROUND_ROBIN_EN swaps fixed dmem-first priority for alternating priority.
module mem_port_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    // state | meaning
    // IDLE  | port idle, mem masks 0
    // GNT_I | imem request on the port
    // GNT_D | dmem request on the port
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t      state;

    logic        pend_i_valid;
    logic [31:0] pend_i_addr;
    logic [3:0]  pend_i_rmask;

    logic        pend_d_valid;
    logic [31:0] pend_d_addr;
    logic [3:0]  pend_d_rmask;
    logic [3:0]  pend_d_wmask;
    logic [31:0] pend_d_wdata;

    logic        req_i, req_d;
    logic        new_i, new_d;
    logic        cand_i, cand_d;
    logic        pick_d;
    logic        grant_i, grant_d;
    logic [31:0] sel_i_addr, sel_d_addr, sel_d_wdata;
    logic [3:0]  sel_i_rmask, sel_d_rmask, sel_d_wmask;

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;
    logic last_grant;
`endif

    always_comb begin
        req_i  = (imem_rmask != 4'd0);
        req_d  = ((dmem_rmask | dmem_wmask) != 4'd0);
        // a request from a requester that is already pending or on the port is dropped
        new_i  = req_i && !pend_i_valid && (state != GNT_I);
        new_d  = req_d && !pend_d_valid && (state != GNT_D);
        cand_i = pend_i_valid || new_i;
        cand_d = pend_d_valid || new_d;

        sel_i_addr  = pend_i_valid ? pend_i_addr  : imem_addr;
        sel_i_rmask = pend_i_valid ? pend_i_rmask : imem_rmask;
        sel_d_addr  = pend_d_valid ? pend_d_addr  : dmem_addr;
        sel_d_rmask = pend_d_valid ? pend_d_rmask : dmem_rmask;
        sel_d_wmask = pend_d_valid ? pend_d_wmask : dmem_wmask;
        sel_d_wdata = pend_d_valid ? pend_d_wdata : dmem_wdata;

`ifdef ARB_ROUND_ROBIN_EN
        pick_d = cand_d && (!cand_i || (last_grant == LAST_I));
`else
        pick_d = cand_d;
`endif

        grant_i = 1'b0;
        grant_d = 1'b0;
        case (state)
            IDLE: begin
                grant_d = pick_d;
                grant_i = cand_i && !pick_d;
            end
            GNT_I:   grant_d = mem_resp && cand_d;
            GNT_D:   grant_i = mem_resp && cand_i;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mem_addr     <= 32'd0;
            mem_rmask    <= 4'd0;
            mem_wmask    <= 4'd0;
            mem_wdata    <= 32'd0;
            pend_i_valid <= 1'b0;
            pend_i_addr  <= 32'd0;
            pend_i_rmask <= 4'd0;
            pend_d_valid <= 1'b0;
            pend_d_addr  <= 32'd0;
            pend_d_rmask <= 4'd0;
            pend_d_wmask <= 4'd0;
            pend_d_wdata <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant   <= LAST_I;
`endif
        end else begin
            if (grant_d) begin
                state     <= GNT_D;
                mem_addr  <= sel_d_addr;
                mem_rmask <= sel_d_rmask;
                mem_wmask <= sel_d_wmask;
                mem_wdata <= sel_d_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                last_grant <= LAST_D;
`endif
            end else if (grant_i) begin
                state     <= GNT_I;
                mem_addr  <= sel_i_addr;
                mem_rmask <= sel_i_rmask;
                mem_wmask <= 4'd0;
                mem_wdata <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
                last_grant <= LAST_I;
`endif
            end else if ((state != IDLE) && mem_resp) begin
                state     <= IDLE;
                mem_rmask <= 4'd0;
                mem_wmask <= 4'd0;
            end

            // a request granted straight from the inputs never touches its pending entry
            if (grant_i) begin
                pend_i_valid <= 1'b0;
            end else if (new_i) begin
                pend_i_valid <= 1'b1;
                pend_i_addr  <= imem_addr;
                pend_i_rmask <= imem_rmask;
            end

            if (grant_d) begin
                pend_d_valid <= 1'b0;
            end else if (new_d) begin
                pend_d_valid <= 1'b1;
                pend_d_addr  <= dmem_addr;
                pend_d_rmask <= dmem_rmask;
                pend_d_wmask <= dmem_wmask;
                pend_d_wdata <= dmem_wdata;
            end
        end
    end

    assign imem_resp  = (state == GNT_I) && mem_resp;
    assign dmem_resp  = (state == GNT_D) && mem_resp;
    assign imem_rdata = imem_resp ? mem_rdata : 32'd0;
    assign dmem_rdata = dmem_resp ? mem_rdata : 32'd0;

    // simulation-only check for a requester issuing a second outstanding request
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(req_i && (pend_i_valid || state == GNT_I)));
            assert (!(req_d && (pend_d_valid || state == GNT_D)));
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; expectations are hand-derived constants.
// Honors ARB_ROUND_ROBIN_EN for the one priority-dependent expectation.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rmask (imem_rmask),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .dmem_addr  (dmem_addr),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .mem_addr   (mem_addr),
        .mem_rmask  (mem_rmask),
        .mem_wmask  (mem_wmask),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_reqs();
        imem_rmask = 4'd0;
        dmem_rmask = 4'd0;
        dmem_wmask = 4'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_reqs();
        mem_resp = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        imem_addr  = 32'd0;
        dmem_addr  = 32'd0;
        dmem_wdata = 32'd0;
        mem_rdata  = 32'd0;
        mem_resp   = 1'b0;
        clear_reqs();
        repeat (3) tick();

        // reset state, with a stale mem_resp present
        chk("rst_mem_addr",  mem_addr,  32'd0);
        chk("rst_mem_rmask", {28'd0, mem_rmask}, 32'd0);
        chk("rst_mem_wmask", {28'd0, mem_wmask}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        mem_resp  = 1'b1;
        mem_rdata = 32'hAAAA5555;
        #1;
        chk("rst_imem_resp",  {31'd0, imem_resp}, 32'd0);
        chk("rst_dmem_resp",  {31'd0, dmem_resp}, 32'd0);
        chk("rst_imem_rdata", imem_rdata, 32'd0);
        chk("rst_dmem_rdata", dmem_rdata, 32'd0);
        rst = 1'b0;
        tick();
        chk("stale_resp_idle", {28'd0, mem_rmask}, 32'd0);
        chk("stale_resp_none", {31'd0, imem_resp | dmem_resp}, 32'd0);
        mem_resp = 1'b0;

        // single fetch
        imem_addr  = 32'h60000000;
        imem_rmask = 4'hF;
        tick();
        clear_reqs();
        chk("fetch_addr",  mem_addr, 32'h60000000);
        chk("fetch_rmask", {28'd0, mem_rmask}, 32'h0000000F);
        chk("fetch_wmask", {28'd0, mem_wmask}, 32'd0);
        tick();
        chk("fetch_wait_resp", {31'd0, imem_resp}, 32'd0);
        chk("fetch_wait_addr", mem_addr, 32'h60000000);
        tick();
        mem_resp  = 1'b1;
        mem_rdata = 32'h00000013;
        #1;
        chk("fetch_resp",  {31'd0, imem_resp}, 32'd1);
        chk("fetch_rdata", imem_rdata, 32'h00000013);
        chk("fetch_no_dresp", {31'd0, dmem_resp}, 32'd0);
        tick();
        mem_resp = 1'b0;
        #1;
        chk("fetch_done_rmask", {28'd0, mem_rmask}, 32'd0);
        chk("fetch_done_resp",  {31'd0, imem_resp}, 32'd0);
        chk("fetch_done_rdata", imem_rdata, 32'd0);

        // simultaneous requests after reset, then a 10-cycle stall on dmem
        do_reset();
        imem_addr  = 32'h60000004;
        imem_rmask = 4'hF;
        dmem_addr  = 32'h70000000;
        dmem_wmask = 4'hF;
        dmem_wdata = 32'hDEADBEEF;
        tick();
        clear_reqs();
        chk("sim_d_addr",  mem_addr, 32'h70000000);
        chk("sim_d_wmask", {28'd0, mem_wmask}, 32'h0000000F);
        chk("sim_d_rmask", {28'd0, mem_rmask}, 32'd0);
        chk("sim_d_wdata", mem_wdata, 32'hDEADBEEF);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_addr",  mem_addr, 32'h70000000);
            chk("stall_wmask", {28'd0, mem_wmask}, 32'h0000000F);
            chk("stall_wdata", mem_wdata, 32'hDEADBEEF);
            chk("stall_resp",  {30'd0, imem_resp, dmem_resp}, 32'd0);
        end
        mem_resp  = 1'b1;
        mem_rdata = 32'h0BADF00D;
        #1;
        chk("sim_d_resp",  {31'd0, dmem_resp}, 32'd1);
        chk("sim_d_rdata", dmem_rdata, 32'h0BADF00D);
        chk("sim_d_no_iresp", {31'd0, imem_resp}, 32'd0);
        tick();
        mem_resp = 1'b0;
        chk("sim_i_addr",  mem_addr, 32'h60000004);
        chk("sim_i_rmask", {28'd0, mem_rmask}, 32'h0000000F);
        chk("sim_i_wmask", {28'd0, mem_wmask}, 32'd0);
        mem_resp  = 1'b1;
        mem_rdata = 32'h11223344;
        #1;
        chk("sim_i_resp",  {31'd0, imem_resp}, 32'd1);
        chk("sim_i_rdata", imem_rdata, 32'h11223344);
        tick();
        mem_resp = 1'b0;
        chk("sim_idle", {24'd0, mem_rmask, mem_wmask}, 32'd0);

        // request arriving in the other requester's completion cycle, minimum round trip
        dmem_addr  = 32'h70000010;
        dmem_rmask = 4'hF;
        tick();
        clear_reqs();
        chk("ovl_d_addr", mem_addr, 32'h70000010);
        mem_resp   = 1'b1;
        mem_rdata  = 32'hCAFE0001;
        imem_addr  = 32'h60000008;
        imem_rmask = 4'hF;
        #1;
        chk("ovl_d_resp",  {31'd0, dmem_resp}, 32'd1);
        chk("ovl_d_rdata", dmem_rdata, 32'hCAFE0001);
        tick();
        clear_reqs();
        mem_rdata = 32'hCAFE0002;
        #1;
        chk("ovl_i_addr",  mem_addr, 32'h60000008);
        chk("ovl_i_rmask", {28'd0, mem_rmask}, 32'h0000000F);
        chk("ovl_i_resp",  {31'd0, imem_resp}, 32'd1);
        chk("ovl_i_rdata", imem_rdata, 32'hCAFE0002);
        tick();
        mem_resp = 1'b0;
        chk("ovl_idle", {24'd0, mem_rmask, mem_wmask}, 32'd0);

        // priority after a dmem grant: round-robin picks imem, fixed picks dmem
        do_reset();
        dmem_addr  = 32'h70000020;
        dmem_rmask = 4'hF;
        tick();
        clear_reqs();
        mem_resp  = 1'b1;
        mem_rdata = 32'h00000055;
        #1;
        chk("pri_first_rdata", dmem_rdata, 32'h00000055);
        tick();
        mem_resp   = 1'b0;
        imem_addr  = 32'h6000000C;
        imem_rmask = 4'hF;
        dmem_addr  = 32'h70000024;
        dmem_rmask = 4'hF;
        tick();
        clear_reqs();
`ifdef ARB_ROUND_ROBIN_EN
        chk("pri_winner", mem_addr, 32'h6000000C);
`else
        chk("pri_winner", mem_addr, 32'h70000024);
`endif
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        chk("pri_second", mem_addr, 32'h70000024);
`else
        chk("pri_second", mem_addr, 32'h6000000C);
`endif
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        chk("pri_idle", {24'd0, mem_rmask, mem_wmask}, 32'd0);

        // reset while dmem owns the port, with imem pending
        do_reset();
        imem_addr  = 32'h60000030;
        imem_rmask = 4'hF;
        dmem_addr  = 32'h70000030;
        dmem_wmask = 4'h3;
        dmem_wdata = 32'h12345678;
        tick();
        clear_reqs();
        chk("mid_gnt_d", {28'd0, mem_wmask}, 32'h00000003);
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        mem_resp = 1'b1;
        #1;
        chk("mid_no_dresp", {31'd0, dmem_resp}, 32'd0);
        chk("mid_no_iresp", {31'd0, imem_resp}, 32'd0);
        chk("mid_masks",    {24'd0, mem_rmask, mem_wmask}, 32'd0);
        tick();
        mem_resp = 1'b0;
        chk("mid_pend_dropped", {24'd0, mem_rmask, mem_wmask}, 32'd0);
        imem_addr  = 32'h60000040;
        imem_rmask = 4'hF;
        tick();
        clear_reqs();
        chk("mid_reissue_addr", mem_addr, 32'h60000040);
        mem_resp = 1'b1;
        #1;
        chk("mid_reissue_resp", {31'd0, imem_resp}, 32'd1);
        tick();
        mem_resp = 1'b0;

        // both requesters re-request right after each completion: grants alternate
        do_reset();
        imem_addr  = 32'h60000100;
        imem_rmask = 4'hF;
        dmem_addr  = 32'h70000100;
        dmem_wmask = 4'hF;
        dmem_wdata = 32'h00000100;
        tick();
        clear_reqs();
        for (int k = 0; k < 8; k++) begin
            logic exp_d;
            exp_d = (k % 2 == 0);
            chk("rr_gnt_dmem", {31'd0, (mem_wmask != 4'd0)}, {31'd0, exp_d});
            chk("rr_gnt_imem", {31'd0, (mem_rmask != 4'd0)}, {31'd0, !exp_d});
            mem_resp = 1'b1;
            #1;
            chk("rr_resp_owner", {30'd0, dmem_resp, imem_resp}, exp_d ? 32'd2 : 32'd1);
            tick();
            clear_reqs();
            mem_resp = 1'b0;
            if (k < 7) begin
                if (exp_d) dmem_wmask = 4'hF;
                else       imem_rmask = 4'hF;
            end
        end
        do_reset();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
